// File: rtl/key_search_ctrl.sv
// key_search_ctrl: walks a key range, launching the RC4 core per key and
// screening its decrypted bytes for a plausible lowercase/space message.
module key_search_ctrl #(
    parameter int                  KEY_BITS  = 24,
    parameter logic [KEY_BITS-1:0] KEY_START = '0,
    parameter logic [KEY_BITS-1:0] KEY_END   = 24'h3FFFFF,
    parameter int                  MSG_LEN   = 32,
    parameter int                  TIMEOUT   = 4096
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                core_start,
    output logic                core_abort,
    input  logic                core_done,
    input  logic                dec_valid,
    input  logic [7:0]          dec_data,
    output logic [KEY_BITS-1:0] key,
    output logic [31:0]         attempts,
    output logic                busy,
    output logic                found,
    output logic                exhausted,
    output logic                timeout_err
);
    localparam int CW = $clog2(MSG_LEN + 1);
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {IDLE, LAUNCH, RUN, ABORT, NEXT, FOUND, FAIL} state_t;

    state_t              state_q, state_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [31:0]         att_q, att_d;
    logic [CW-1:0]       cnt_q, cnt_d, cnt_acc;
    logic [WW-1:0]       wd_q, wd_d;
    logic                terr_q, terr_d;
    logic                legal, reject;

    assign legal   = (dec_data >= 8'h61 && dec_data <= 8'h7A) || dec_data == 8'h20;
    assign reject  = dec_valid && (!legal || cnt_q == CW'(MSG_LEN));
    // a legal byte arriving with core_done still counts toward the full message
    assign cnt_acc = cnt_q + CW'(dec_valid && !reject);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= KEY_START;
            att_q   <= '0;
            cnt_q   <= '0;
            wd_q    <= '0;
            terr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            att_q   <= att_d;
            cnt_q   <= cnt_d;
            wd_q    <= wd_d;
            terr_q  <= terr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        att_d   = att_q;
        cnt_d   = cnt_q;
        wd_d    = wd_q;
        terr_d  = terr_q;
        case (state_q)
            IDLE, FOUND, FAIL: begin
                if (start) begin
                    key_d   = KEY_START;
                    att_d   = '0;
                    terr_d  = 1'b0;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                wd_d    = '0;
                att_d   = &att_q ? att_q : att_q + 32'd1;
                state_d = RUN;
            end
            RUN: begin
                cnt_d = cnt_acc;
                wd_d  = wd_q + WW'(1);
                if (reject) begin
                    state_d = ABORT;
                end else if (core_done) begin
                    state_d = (cnt_acc == CW'(MSG_LEN)) ? FOUND : NEXT;
                end else if (wd_q == WW'(TIMEOUT - 1)) begin
                    state_d = ABORT;
                    terr_d  = 1'b1;
                end
            end
            ABORT: state_d = NEXT;
            NEXT: begin
                state_d = (key_q == KEY_END) ? FAIL : LAUNCH;
                key_d   = (key_q == KEY_END) ? key_q : key_q + KEY_BITS'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    assign core_start  = state_q == LAUNCH;
    assign core_abort  = state_q == ABORT;
    assign busy        = state_q inside {LAUNCH, RUN, ABORT, NEXT};
    assign found       = state_q == FOUND;
    assign exhausted   = state_q == FAIL;
    assign key         = key_q;
    assign attempts    = att_q;
    assign timeout_err = terr_q;
endmodule

// File: tb/tb_key_search_ctrl.sv
// tb_key_search_ctrl: directed scenarios against a latency-schedule model of
// the key search, plus watchdog and single-key instances checked directly.
module tb_key_search_ctrl;
    localparam int             KB = 24;
    localparam logic [KB-1:0]  KS = 24'd0;
    localparam logic [KB-1:0]  KE = 24'd3;
    localparam int             ML = 32;
    localparam int             TO = 64;

    logic clk = 1'b0;
    logic rst, start, core_done, dec_valid;
    logic [7:0] dec_data;
    logic core_start, core_abort, busy, found, exhausted, timeout_err;
    logic [KB-1:0] key;
    logic [31:0] attempts;

    logic start_t, zero = 1'b0;
    logic [7:0] zb = 8'h00;
    logic cs_t, ca_t, busy_t, found_t, exh_t, terr_t, cs_s, ca_s, busy_s, found_s, exh_s, terr_s;
    logic [KB-1:0] key_t, key_s;
    logic [31:0] att_t, att_s;

    int n_chk = 0, n_fail = 0;
    int st_cnt = 0, ab_cnt = 0, st_t_cnt = 0, st_s_cnt = 0;

    always #5 clk = ~clk;

    key_search_ctrl #(.KEY_BITS(KB), .KEY_START(KS), .KEY_END(KE), .MSG_LEN(ML), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .core_start(core_start), .core_abort(core_abort),
        .core_done(core_done), .dec_valid(dec_valid), .dec_data(dec_data), .key(key),
        .attempts(attempts), .busy(busy), .found(found), .exhausted(exhausted), .timeout_err(timeout_err));

    key_search_ctrl #(.KEY_BITS(KB), .KEY_START(24'd1), .KEY_END(24'd2), .MSG_LEN(ML), .TIMEOUT(16)) dut_t (
        .clk(clk), .rst(rst), .start(start_t), .core_start(cs_t), .core_abort(ca_t),
        .core_done(zero), .dec_valid(zero), .dec_data(zb), .key(key_t),
        .attempts(att_t), .busy(busy_t), .found(found_t), .exhausted(exh_t), .timeout_err(terr_t));

    key_search_ctrl #(.KEY_BITS(KB), .KEY_START(24'd5), .KEY_END(24'd5), .MSG_LEN(ML), .TIMEOUT(16)) dut_s (
        .clk(clk), .rst(rst), .start(start_t), .core_start(cs_s), .core_abort(ca_s),
        .core_done(zero), .dec_valid(zero), .dec_data(zb), .key(key_s),
        .attempts(att_s), .busy(busy_s), .found(found_s), .exhausted(exh_s), .timeout_err(terr_s));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (core_start) st_cnt++;
        if (core_abort) ab_cnt++;
        if (cs_t) st_t_cnt++;
        if (cs_s) st_s_cnt++;
    end

    // Model: each outcome is scheduled as absolute cycles from the latency rules
    int cyc = 0, launch_at = -1, abort_at = -1, fail_at = -1, busy_until = -1;
    int m_bytes, m_wd;
    logic m_run, m_found, m_exh, m_terr;
    logic [KB-1:0] m_key, pend_key;
    logic [31:0] m_att;

    task automatic fin(input int x);
        busy_until = x - 1;
        if (m_key == KE) fail_at = x;
        else begin
            launch_at = x;
            pend_key  = m_key + 1'b1;
        end
    endtask

    always @(posedge clk) begin : model
        bit legal, rej, bz;
        int nb, n;
        n  = cyc + 1;
        bz = m_run || cyc == launch_at || cyc <= busy_until;
        if (rst) begin
            m_run = 0; m_found = 0; m_exh = 0; m_terr = 0; m_key = KS; m_att = 0;
            launch_at = -1; abort_at = -1; fail_at = -1; busy_until = -1;
        end else if (!bz && start) begin
            m_key = KS; pend_key = KS; m_att = 0; m_terr = 0; m_found = 0; m_exh = 0;
            launch_at = n;
        end else if (cyc == launch_at) begin
            m_run = 1; m_bytes = 0; m_wd = 0;
            if (m_att != '1) m_att++;
        end else if (m_run) begin
            legal = dec_data inside {[8'h61:8'h7A], 8'h20};
            rej   = dec_valid && (!legal || m_bytes == ML);
            nb    = m_bytes + ((dec_valid && !rej) ? 1 : 0);
            if (rej || (!core_done && m_wd == TO - 1)) begin
                m_run = 0; abort_at = n;
                if (!rej) m_terr = 1;
                fin(n + 2);
            end else if (core_done && nb == ML) begin
                m_run = 0; m_found = 1;
            end else if (core_done) begin
                m_run = 0;
                fin(n + 1);
            end else begin
                m_bytes = nb; m_wd++;
            end
        end
        if (!rst && n == launch_at) m_key = pend_key;
        if (!rst && n == fail_at) m_exh = 1;
        cyc = n;
    end

    always @(negedge clk) begin
        if (cyc > 0) begin
            chk("m_core_start", core_start, cyc == launch_at);
            chk("m_core_abort", core_abort, cyc == abort_at);
            chk("m_busy", busy, m_run || cyc == launch_at || cyc <= busy_until);
            chk("m_found", found, m_found);
            chk("m_exhausted", exhausted, m_exh);
            chk("m_key", key, m_key);
            chk("m_attempts", attempts, m_att);
            chk("m_timeout_err", timeout_err, m_terr);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [7:0] d, input logic dn);
        dec_valid = v; dec_data = d; core_done = dn;
    endtask

    function automatic logic [7:0] lb(input int i);
        return (i % 4 == 0) ? 8'h61 : (i % 4 == 1) ? 8'h7A : (i % 4 == 2) ? 8'h20 : 8'h71;
    endfunction

    task automatic attempt(input int mode);
        logic [KB-1:0] k;
        k = key;
        step;
        case (mode)
            0: begin
                for (int i = 0; i < ML - 1; i++) begin drv(1, lb(i), 0); step; end
                drv(1, 8'h20, 1); step; drv(0, 0, 0);
            end
            1: begin
                for (int i = 0; i < ML; i++) begin
                    if (i % 8 == 3) begin drv(0, 8'h7B, 0); start = 1; step; start = 0; end
                    drv(1, lb(i), 0); step;
                end
                drv(0, 0, 0); step; drv(0, 0, 1); step; drv(0, 0, 0);
            end
            2: begin
                drv(1, 8'h7B, 0); step; drv(0, 0, 0);
                chk("bad_abort_t1", core_abort, 1);
                step; step;
                if (k == KE) chk("bad_exh_t3", exhausted, 1);
                else begin
                    chk("bad_start_t3", core_start, 1);
                    chk("bad_key_t3", key, k + 1);
                end
            end
            3: begin
                for (int i = 0; i < ML - 1; i++) begin drv(1, lb(i), 0); step; end
                drv(0, 0, 1); step; drv(0, 0, 0); step;
                if (k == KE) chk("short_exh_t2", exhausted, 1);
                else begin
                    chk("short_start_t2", core_start, 1);
                    chk("short_key_t2", key, k + 1);
                end
            end
            4: begin
                for (int i = 0; i < ML; i++) begin drv(1, lb(i), 0); step; end
                drv(1, lb(0), 0); step; drv(0, 0, 0);
                chk("overrun_abort", core_abort, 1);
            end
            5: begin
                for (int i = 0; i < 10; i++) begin drv(1, lb(i), 0); step; end
                drv(1, 8'h60, 1); step; drv(0, 0, 0);
                chk("reject_wins_abort", core_abort, 1);
            end
            default: ;
        endcase
    endtask

    task automatic search(input int m0, input int m1, input int m2, input int m3);
        int modes[4];
        modes = '{m0, m1, m2, m3};
        start = 1; step; start = 0;
        for (int a = 0; a < 10; a++) begin
            int i;
            i = 0;
            while (!(core_start || found || exhausted) && i < 400) begin step; i++; end
            if (i == 400) begin
                chk("wait_launch_bound", core_start || found || exhausted, 1);
                return;
            end
            if (found || exhausted) return;
            attempt(modes[key[1:0]]);
        end
    endtask

    initial begin
        int base, n;
        rst = 1; start = 0; start_t = 0; drv(0, 0, 0);
        repeat (3) step;
        rst = 0; step;
        chk("rst_busy", busy, 0);
        chk("rst_key", key, 0);
        chk("rst_attempts", attempts, 0);
        drv(1, 8'h7B, 1); repeat (3) step; drv(0, 0, 0);
        chk("idle_noise_busy", busy, 0);
        chk("idle_noise_abort_cnt", ab_cnt, 0);

        search(2, 3, 0, 0);
        chk("s1_found", found, 1);
        chk("s1_key", key, 2);
        chk("s1_attempts", attempts, 3);
        chk("s1_busy", busy, 0);

        base = st_cnt;
        search(4, 5, 3, 2);
        chk("s2_exhausted", exhausted, 1);
        chk("s2_key", key, 3);
        chk("s2_attempts", attempts, 4);
        chk("s2_launches", st_cnt - base, 4);

        search(1, 1, 1, 1);
        chk("s3_found", found, 1);
        chk("s3_attempts", attempts, 1);

        base = ab_cnt;
        start = 1; step; start = 0; step;
        for (int i = 0; i < 5; i++) begin drv(1, lb(i), 0); step; end
        rst = 1; drv(0, 0, 0); step; rst = 0;
        chk("rr_core_start", core_start, 0);
        chk("rr_core_abort", core_abort, 0);
        chk("rr_busy", busy, 0);
        chk("rr_found", found, 0);
        chk("rr_exhausted", exhausted, 0);
        chk("rr_timeout_err", timeout_err, 0);
        chk("rr_attempts", attempts, 0);
        chk("rr_key", key, 0);
        step; step;
        chk("rr_no_abort", ab_cnt - base, 0);
        search(0, 0, 0, 0);
        chk("rr_found_again", found, 1);
        chk("rr_attempts_again", attempts, 1);

        base = st_t_cnt;
        start_t = 1; step; start_t = 0;
        chk("t_launch", cs_t, 1);
        n = 0;
        while (!ca_t && n < 100) begin step; n++; end
        chk("t_abort_latency", n, 17);
        chk("t_terr_set", terr_t, 1);
        step; step;
        chk("t_continue_start", cs_t, 1);
        chk("t_continue_key", key_t, 2);
        chk("t_terr_sticky", terr_t, 1);
        chk("s_exhausted", exh_s, 1);
        chk("s_attempts", att_s, 1);
        chk("s_key", key_s, 5);
        chk("s_launches", st_s_cnt, 1);
        n = 0;
        while (!exh_t && n < 100) begin step; n++; end
        chk("t_exhausted", exh_t, 1);
        chk("t_attempts", att_t, 2);
        chk("t_terr_end", terr_t, 1);
        chk("t_launches", st_t_cnt - base, 2);
        start_t = 1; step; start_t = 0;
        chk("t_restart_terr", terr_t, 0);
        chk("t_restart_attempts", att_t, 0);
        chk("t_restart_key", key_t, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
        $fatal(1);
    end
endmodule

// File: doc/key_search_ctrl.md
KEY_SEARCH_CTRL -- requirements
Module: key_search_ctrl

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
  - KEY_BITS, 24, key width.
  - KEY_START, 0, first candidate key.
  - KEY_END, 24'h3FFFFF, last candidate key, inclusive.
  - MSG_LEN, 32, expected decrypted byte count.
  - TIMEOUT, 4096, maximum RUN cycles per attempt.
REQ-002 The block SHALL have these ports (name, direction, width, meaning):
  - clk, in, 1, clock.
  - rst, in, 1, synchronous active-high reset.
  - start, in, 1, begin search.
  - core_start, out, 1, one-cycle launch of the RC4 phase sequencer.
  - core_abort, out, 1, one-cycle abort of the RC4 phase sequencer.
  - core_done, in, 1, sequencer finished all phases.
  - dec_valid, in, 1, decrypted byte strobe.
  - dec_data, in, 8, decrypted byte.
  - key, out, KEY_BITS, current candidate key.
  - attempts, out, 32, keys tried.
  - busy, out, 1, search in progress.
  - found, out, 1, valid key located.
  - exhausted, out, 1, key space ended without a match.
  - timeout_err, out, 1, sticky watchdog flag.
REQ-003 Reset SHALL be rst, synchronous, active-high; the clock SHALL be clk; all state SHALL update on the rising edge of clk.

Function
REQ-004 The FSM SHALL have the states IDLE, LAUNCH, RUN, ABORT, NEXT, FOUND and FAIL; any illegal encoding SHALL go to IDLE.
REQ-005 The outputs SHALL be Moore outputs: core_start=1 only in LAUNCH; core_abort=1 only in ABORT; busy=1 in LAUNCH, RUN, ABORT and NEXT.
REQ-006 found SHALL be 1 only in FOUND, and exhausted SHALL be 1 only in FAIL.
REQ-007 IDLE, FOUND and FAIL SHALL respond to start=1 as follows: key<=KEY_START, attempts<=0, timeout_err<=0, next state LAUNCH; otherwise they hold. FOUND and FAIL SHALL keep key stable.
REQ-008 LAUNCH SHALL clear byte_cnt and the cycle watchdog, increment attempts, and go to RUN after exactly one cycle.
REQ-009 A byte SHALL be legal if dec_data is 8'h61-8'h7A ('a'-'z') or 8'h20 (space).
REQ-010 In RUN, dec_valid=1 with a legal byte and byte_cnt<MSG_LEN SHALL increment byte_cnt.
REQ-011 In RUN, dec_valid=1 with an illegal byte, or with byte_cnt==MSG_LEN (overrun), SHALL cause a transition to ABORT.
REQ-012 In RUN, core_done=1 with no same-cycle reject SHALL go to FOUND if byte_cnt==MSG_LEN, else to NEXT (short message is a reject).
REQ-013 When a reject and core_done occur in the same cycle, the reject SHALL win and the state SHALL go to ABORT.
REQ-014 The RUN watchdog SHALL count cycles; on reaching TIMEOUT-1 without a transition, the state SHALL go to ABORT and timeout_err SHALL be set (sticky until start or rst).
REQ-015 ABORT SHALL last one cycle and then go to NEXT.
REQ-016 NEXT SHALL go to FAIL if key==KEY_END (key unchanged); otherwise key<=key+1 and next state LAUNCH.
REQ-017 The key increment SHALL not wrap past KEY_END.
REQ-018 attempts SHALL saturate at 32'hFFFFFFFF.
REQ-019 dec_valid and core_done SHALL be ignored in every state except RUN.
REQ-020 start SHALL be ignored while busy=1.
REQ-021 Latency: from an illegal byte sampled in RUN at cycle t, core_abort SHALL be 1 at t+1 and core_start (next key) SHALL be 1 at t+3.
REQ-022 Latency: from core_done accepted as a reject at t, core_start SHALL be 1 at t+2.
REQ-023 If KEY_START==KEY_END, exactly one attempt SHALL be made.

Reset
REQ-024 With rst=1 at a clock edge, the state SHALL become IDLE and key=KEY_START, attempts=0, byte_cnt=0, watchdog=0, timeout_err=0.
REQ-025 On that reset, all outputs SHALL be deasserted.
REQ-026 rst SHALL take priority over every input, including mid-RUN; no core_abort SHALL be issued on reset.

Verification
REQ-027 KEY_START=0, KEY_END=3, core model emits 32 legal bytes only for key 2 -> found=1, key=2, attempts=3, busy=0.
REQ-028 Same range, no valid key -> exhausted=1, key=3, attempts=4, exactly 4 core_start pulses.
REQ-029 Key 0, byte 8'h7B at byte index 0 in cycle t -> core_abort at t+1, core_start at t+3 with key=1.
REQ-030 core_done after 31 legal bytes -> reject, NEXT, then core_start with key+1; 8'h20 and dec_valid together with core_done at count 32 -> found.
REQ-031 Core model never asserts core_done, TIMEOUT=16 -> ABORT after 16 RUN cycles, timeout_err=1 (sticky), search continues.
REQ-032 rst asserted during RUN, then start -> all outputs 0 after reset edge, no core_abort, fresh search from KEY_START with attempts restarting at 1.
